// File: rtl/ph_frame_cache.sv
// ph_frame_cache -- double-buffered pulse-height frame cache.
//
// Takes frames from the MAROC capture AXI-Stream. Each frame is split into a
// leading skip region (SKIP_N beats), a capture region decimated as KEEP_N
// kept beats out of every GROUP_N, and a trailer that is thrown away up to
// tlast. Captured samples fill one of two banks. Completed banks go to the
// consumer oldest-first, and a host port can read either bank at any time.
// Frames that arrive while both banks are full are dropped. Frames cut short
// by an early tlast pulse frm_err.
//
// Optional feature macro: PH_CACHE_DROP_CNT_EN adds the drop_cnt port and a
// 16-bit saturating dropped-frame counter.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready  input stream (never backpressured)
//   cache_valid       at least one bank holds a complete frame
//   rd_sel            oldest full bank, the one the consumer port reads
//   rd_en/rd_addr/rd_data  consumer read port, 1-cycle latency, data holds
//   rd_done           one-cycle pulse that releases bank rd_sel
//   host_en/host_bank/host_addr/host_data  host read port, non-destructive
//   frm_err           one-cycle pulse after a truncated frame
//   busy              frame FSM is not idle
//   drop_cnt          dropped-frame count (PH_CACHE_DROP_CNT_EN only)
module ph_frame_cache #(
  parameter int DATA_W  = 16,
  parameter int N_SAMP  = 128,
  parameter int SKIP_N  = 20,
  parameter int GROUP_N = 4,
  parameter int KEEP_N  = 2,
  localparam int ADDR_W = $clog2(N_SAMP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              cache_valid,
  output logic              rd_sel,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  input  logic              host_en,
  input  logic              host_bank,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_data,
  output logic              frm_err,
  output logic              busy
`ifdef PH_CACHE_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(SKIP_N + 1);
  localparam int GRP_W = (GROUP_N > 1) ? $clog2(GROUP_N) : 1;

  typedef enum logic [2:0] {IDLE, SKIP, CAPTURE, TRAIL, DROP} state_t;

  state_t            state;
  logic              tvalid_d1;
  logic              wr_bank;
  logic              last_bank;
  logic [CNT_W-1:0]  beat_cnt;
  logic [GRP_W-1:0]  grp_idx;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        full;

  // Both banks share one array, addressed as {bank, sample}.
  logic [DATA_W-1:0] mem [0:(2 << ADDR_W)-1];

  logic       start;
  logic       keep;
  logic       last_write;
  logic       complete;
  logic       release_bank;
  logic       pick_bank;
  logic [1:0] full_rel;
  logic [1:0] full_next;
  logic       rd_sel_next;

  assign start      = s_tvalid && !tvalid_d1 && (state == IDLE);
  assign keep       = (state == CAPTURE) && s_tvalid && (32'(grp_idx) < KEEP_N);
  assign last_write = keep && (waddr == ADDR_W'(N_SAMP - 1));
  assign complete   = ((state == TRAIL) && s_tvalid && s_tlast) || (last_write && s_tlast);

  // With one bank full, write the other; with both free, alternate.
  assign pick_bank = (full[0] | full[1]) ? full[0] : ~last_bank;

  // Release is applied before completion so both can land in one cycle.
  assign release_bank = rd_done && (full != 2'b00);
  assign full_rel     = release_bank ? (full & ~(2'b01 << rd_sel)) : full;
  assign full_next    = full_rel | (complete ? (2'b01 << wr_bank) : 2'b00);

  // Oldest full bank: a bank that survives the release is older than any bank
  // completing now, since the write bank was free when its frame began.
  always_comb begin
    rd_sel_next = rd_sel;
    if (full_rel == 2'b11)
      rd_sel_next = rd_sel;
    else if (full_rel != 2'b00)
      rd_sel_next = full_rel[1];
    else if (complete)
      rd_sel_next = wr_bank;
  end

  assign cache_valid = |full;
  assign busy        = (state != IDLE);

  generate
    if (DATA_W < 32) begin : g_tdata_hi
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s_tdata[31:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (keep)
      mem[{wr_bank, waddr}] <= s_tdata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= '0;
      host_data <= '0;
    end else begin
      if (rd_en)
        rd_data <= mem[{rd_sel, rd_addr}];
      if (host_en)
        host_data <= mem[{host_bank, host_addr}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tvalid_d1 <= 1'b0;
      wr_bank   <= 1'b0;
      last_bank <= 1'b1;
      beat_cnt  <= '0;
      grp_idx   <= '0;
      waddr     <= '0;
      full      <= 2'b00;
      rd_sel    <= 1'b0;
      frm_err   <= 1'b0;
      s_tready  <= 1'b0;
    end else begin
      s_tready  <= 1'b1;
      tvalid_d1 <= s_tvalid;
      frm_err   <= 1'b0;
      full      <= full_next;
      rd_sel    <= rd_sel_next;
      case (state)
        IDLE: begin
          if (start) begin
            if (s_tlast) begin
              frm_err <= 1'b1;
            end else if (full != 2'b11) begin
              wr_bank   <= pick_bank;
              last_bank <= pick_bank;
              beat_cnt  <= CNT_W'(1);
              grp_idx   <= '0;
              waddr     <= '0;
              state     <= (SKIP_N == 1) ? CAPTURE : SKIP;
            end else begin
              state <= DROP;
            end
          end
        end
        SKIP: begin
          if (s_tvalid) begin
            if (s_tlast) begin
              frm_err <= 1'b1;
              state   <= IDLE;
            end else if (beat_cnt == CNT_W'(SKIP_N - 1)) begin
              grp_idx <= '0;
              waddr   <= '0;
              state   <= CAPTURE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (s_tvalid) begin
            grp_idx <= (grp_idx == GRP_W'(GROUP_N - 1)) ? '0 : grp_idx + 1'b1;
            if (keep)
              waddr <= waddr + 1'b1;
            if (last_write) begin
              state <= s_tlast ? IDLE : TRAIL;
            end else if (s_tlast) begin
              frm_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        TRAIL, DROP: begin
          if (s_tvalid && s_tlast)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PH_CACHE_DROP_CNT_EN
  logic enter_drop;
  assign enter_drop = start && !s_tlast && (full == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= 16'd0;
    else if (enter_drop && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ph_frame_cache.sv
// Testbench for ph_frame_cache: directed scenarios with random frame data,
// checked against a frame-level reference model (bank arrays, full flags and
// a completion-order queue).
module tb_ph_frame_cache;
  localparam int DATA_W  = 16;
  localparam int N_SAMP  = 128;
  localparam int SKIP_N  = 20;
  localparam int GROUP_N = 4;
  localparam int KEEP_N  = 2;
  localparam int ADDR_W  = 7;
  localparam int FRAME_N = SKIP_N + (N_SAMP / KEEP_N) * GROUP_N + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic              cache_valid;
  logic              rd_sel;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done = 1'b0;
  logic              host_en = 1'b0;
  logic              host_bank = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_data;
  logic              frm_err;
  logic              busy;
`ifdef PH_CACHE_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  ph_frame_cache dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .cache_valid(cache_valid), .rd_sel(rd_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .host_en(host_en), .host_bank(host_bank), .host_addr(host_addr), .host_data(host_data),
    .frm_err(frm_err), .busy(busy)
`ifdef PH_CACHE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic busy_mid = 1'b0;

  // Reference model
  logic [31:0]       fdata [0:511];
  logic [DATA_W-1:0] mmem  [0:1][0:N_SAMP-1];
  bit                mfull [0:1];
  int                mq[$];
  bit                mlast;
  int                mdrop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (frm_err === 1'b1) err_pulses++;
  endtask

  function automatic int samp_beat(input int k);
    return SKIP_N + (k / KEEP_N) * GROUP_N + (k % KEEP_N);
  endfunction

  task automatic model_reset();
    mfull[0] = 0; mfull[1] = 0;
    mq.delete();
    mlast = 1;
    mdrop = 0;
  endtask

  // Frame whose start beat is accepted (not a tlast-on-start frame).
  task automatic model_frame(input bit complete);
    int bank;
    if (mfull[0] && mfull[1]) begin
      if (mdrop < 65535) mdrop++;
      return;
    end
    bank = mfull[0] ? 1 : (mfull[1] ? 0 : (mlast ? 0 : 1));
    mlast = bank[0];
    if (complete) begin
      for (int k = 0; k < N_SAMP; k++) mmem[bank][k] = fdata[samp_beat(k)][DATA_W-1:0];
      mfull[bank] = 1;
      mq.push_back(bank);
    end
  endtask

  task automatic model_release();
    int b;
    if (mq.size() > 0) begin
      b = mq.pop_front();
      mfull[b] = 0;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".cache_valid"}, 32'(cache_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, ".rd_sel"}, 32'(rd_sel), 32'(mq[0]));
  endtask

  // Drives one frame, one beat per cycle unless stalls are requested. Starts
  // with an idle cycle so the first beat is seen as a frame start. Returns on
  // the falling edge right after the last beat was sampled.
  task automatic send_frame(input int nb, input bit idx_data, input bit stalls,
                            input bit done_last, input bit with_last);
    s_tvalid = 0; s_tlast = 0;
    tick();
    for (int b = 0; b < nb; b++) begin
      if (stalls && b > 0 && $urandom_range(0, 3) == 0) begin
        s_tvalid = 0; s_tlast = 0; rd_done = 0;
        repeat ($urandom_range(1, 5)) tick();
      end
      if (b == 10) busy_mid = busy;
      s_tvalid = 1;
      s_tdata  = idx_data ? 32'(b) : $urandom();
      fdata[b] = s_tdata;
      s_tlast  = with_last && (b == nb - 1);
      rd_done  = done_last && (b == nb - 1);
      tick();
    end
    s_tvalid = 0; s_tlast = 0; rd_done = 0;
  endtask

  task automatic crd(input int a, output logic [31:0] d);
    rd_en = 1; rd_addr = a[ADDR_W-1:0];
    tick();
    d = 32'(rd_data);
    rd_en = 0;
  endtask

  task automatic hrd(input int bank, input int a, output logic [31:0] d);
    host_en = 1; host_bank = bank[0]; host_addr = a[ADDR_W-1:0];
    tick();
    d = 32'(host_data);
    host_en = 0;
  endtask

  task automatic chk_host_bank(input int bank, input string tag);
    logic [31:0] d;
    for (int k = 0; k < N_SAMP; k++) begin
      hrd(bank, k, d);
      chk($sformatf("%s[%0d]", tag, k), d, 32'(mmem[bank][k]));
    end
  endtask

  task automatic chk_cons(input string tag);
    logic [31:0] d;
    int a;
    for (int i = 0; i < 10; i++) begin
      a = (i < 4) ? i : ((i == 4) ? N_SAMP - 1 : $urandom_range(0, N_SAMP - 1));
      crd(a, d);
      chk($sformatf("%s[%0d]", tag, a), d, 32'(mmem[mq[0]][a]));
    end
  endtask

  task automatic pulse_done();
    rd_done = 1;
    tick();
    rd_done = 0;
    model_release();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0; s_tvalid = 0; s_tlast = 0; rd_en = 0; host_en = 0; rd_done = 0;
    tick(); tick();
    chk({tag, ".cache_valid"}, 32'(cache_valid), 0);
    chk({tag, ".rd_sel"}, 32'(rd_sel), 0);
    chk({tag, ".rd_data"}, 32'(rd_data), 0);
    chk({tag, ".host_data"}, 32'(host_data), 0);
    chk({tag, ".frm_err"}, 32'(frm_err), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".s_tready"}, 32'(s_tready), 0);
`ifdef PH_CACHE_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
`endif
    rst_n = 1;
    tick();
    model_reset();
    chk({tag, ".s_tready_run"}, 32'(s_tready), 1);
  endtask

  initial begin
    logic [31:0] d;
    int a1[5];
    int e1[5];
    a1 = '{0, 1, 2, 3, N_SAMP - 1};
    e1 = '{20, 21, 24, 25, 273};

    // 1. Single frame with tdata = beat index
    do_reset("rst1");
    err_pulses = 0;
    send_frame(FRAME_N, 1, 0, 0, 1);
    model_frame(1);
    chk("s1.cache_valid", 32'(cache_valid), 1);
    chk("s1.rd_sel", 32'(rd_sel), 0);
    for (int i = 0; i < 5; i++) begin
      crd(a1[i], d);
      chk($sformatf("s1.rd[%0d]", a1[i]), d, 32'(e1[i]));
    end
    tick();
    chk("s1.rd_hold", 32'(rd_data), 273);
    chk_cons("s1.model");
    chk("s1.frm_err_cnt", 32'(err_pulses), 0);
    chk("s1.busy_idle", 32'(busy), 0);

    // 2. Ping-pong
    do_reset("rst2");
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    chk_status("s2.both");
    hrd(1, 0, d);
    chk("s2.host_b1a0", d, 32'(fdata[SKIP_N][DATA_W-1:0]));
    chk_host_bank(0, "s2.b0");
    chk_host_bank(1, "s2.b1");
    pulse_done();
    chk("s2.rel_rd_sel", 32'(rd_sel), 1);
    chk("s2.rel_valid", 32'(cache_valid), 1);
    chk_cons("s2.rel");
    pulse_done();
    chk_status("s2.empty");

    // 3. Overflow: third frame dropped, fourth lands in bank 0
    do_reset("rst3");
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    chk("s3.drop_busy", 32'(busy_mid), 1);
    chk("s3.drop_idle", 32'(busy), 0);
`ifdef PH_CACHE_DROP_CNT_EN
    chk("s3.drop_cnt", 32'(drop_cnt), 32'(mdrop));
    chk("s3.drop_cnt_one", 32'(drop_cnt), 1);
`endif
    chk_status("s3.after_drop");
    chk_host_bank(0, "s3.keep_b0");
    chk_host_bank(1, "s3.keep_b1");
    pulse_done();
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    hrd(0, 0, d);
    chk("s3.fourth_b0a0", d, 32'(fdata[SKIP_N][DATA_W-1:0]));
    chk_host_bank(0, "s3.fourth_b0");
    chk_status("s3.fourth");

    // 4. Truncation: capture beat 100, skip region, and start beat
    do_reset("rst4");
    err_pulses = 0;
    send_frame(SKIP_N + 101, 0, 0, 0, 1); model_frame(0);
    chk("s4.frm_err_now", 32'(frm_err), 1);
    tick(); tick();
    chk("s4.frm_err_cnt_cap", 32'(err_pulses), 1);
    chk("s4.valid_cap", 32'(cache_valid), 0);
    send_frame(6, 0, 0, 0, 1); model_frame(0);
    tick();
    chk("s4.frm_err_cnt_skip", 32'(err_pulses), 2);
    send_frame(1, 0, 0, 0, 1);
    tick();
    chk("s4.frm_err_cnt_start", 32'(err_pulses), 3);
    chk("s4.busy_start", 32'(busy), 0);
    chk("s4.valid_trunc", 32'(cache_valid), 0);
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    chk("s4.valid_full", 32'(cache_valid), 1);
    chk_cons("s4.full");
    chk("s4.frm_err_cnt_end", 32'(err_pulses), 3);

    // 5. Stalls with rd_done on the completion cycle
    do_reset("rst5");
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    send_frame(FRAME_N, 1, 1, 1, 1); model_release(); model_frame(1);
    chk_status("s5.sim");
    chk("s5.rd_sel", 32'(rd_sel), 1);
    for (int i = 0; i < 5; i++) begin
      crd(a1[i], d);
      chk($sformatf("s5.rd[%0d]", a1[i]), d, 32'(e1[i]));
    end
    chk_cons("s5.model");
    pulse_done();
    chk("s5.one_left", 32'(cache_valid), 0);

    // 6. Reset mid-capture
    do_reset("rst6");
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    crd(5, d);
    hrd(0, 7, d);
    send_frame(SKIP_N + 100, 0, 0, 0, 0);
    chk("s6.busy_pre", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("s6.async.cache_valid", 32'(cache_valid), 0);
    chk("s6.async.rd_sel", 32'(rd_sel), 0);
    chk("s6.async.rd_data", 32'(rd_data), 0);
    chk("s6.async.host_data", 32'(host_data), 0);
    chk("s6.async.frm_err", 32'(frm_err), 0);
    chk("s6.async.busy", 32'(busy), 0);
    chk("s6.async.s_tready", 32'(s_tready), 0);
`ifdef PH_CACHE_DROP_CNT_EN
    chk("s6.async.drop_cnt", 32'(drop_cnt), 0);
`endif
    s_tvalid = 0;
    tick();
    rst_n = 1;
    tick();
    model_reset();
    send_frame(FRAME_N, 0, 0, 0, 1); model_frame(1);
    chk("s6.rd_sel", 32'(rd_sel), 0);
    chk_status("s6.after");
    chk_host_bank(0, "s6.b0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ph_frame_cache.md
# ph_frame_cache

Parametrised double-buffered pulse-height frame cache between the MAROC data-capture AXI-Stream output and the PH baseline/consumer logic. Each stream frame has:

- a leading ADC-latency skip region;
- a capture region, decimated by a keep-of-group pattern;
- a trailer, discarded up to `tlast`.

Captured samples are written into one of two banks. Completed banks are handed to the consumer in order. A non-destructive host port reads either bank. Frames arriving while both banks are full are dropped cleanly, and truncated frames are flagged.

## Interface

**Parameters**

- `DATA_W`, 16: stored sample width (1..32); `s_tdata[DATA_W-1:0]` is stored.
- `N_SAMP`, 128: samples stored per frame (≥2); `ADDR_W = $clog2(N_SAMP)` (localparam).
- `SKIP_N`, 20: beats discarded at frame start, including the first beat (≥1).
- `GROUP_N`, 4: capture-region group length in beats (≥1).
- `KEEP_N`, 2: beats kept at the start of each group (1..`GROUP_N`).

**Ports**

Reset is asynchronous, active-low.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `s_tdata` in 32: stream data.
- `s_tvalid` in 1: stream valid.
- `s_tlast` in 1: stream last.
- `s_tready` out 1: 0 in reset, 1 otherwise; never backpressures.
- `cache_valid` out 1: at least one bank is full.
- `rd_sel` out 1: oldest full bank; consumer reads come from it.
- `rd_en` in 1: consumer read enable.
- `rd_addr` in `ADDR_W`: consumer read address.
- `rd_data` out `DATA_W`: consumer read data; 1-cycle latency, holds when `rd_en`=0.
- `rd_done` in 1: single-cycle pulse; releases bank `rd_sel`.
- `host_en` in 1: host read enable.
- `host_bank` in 1: host read bank select.
- `host_addr` in `ADDR_W`: host read address.
- `host_data` out `DATA_W`: host read data; 1-cycle latency, non-destructive.
- `frm_err` out 1: one-cycle pulse when a frame is truncated.
- `busy` out 1: state ≠ IDLE.
- `drop_cnt` out 16: dropped-frame count; present only with `PH_CACHE_DROP_CNT_EN`.

## Operation

**Definitions**

- A *beat* is any cycle with `s_tvalid`=1.
- A *frame start* is a beat in IDLE whose previous cycle had `s_tvalid`=0 (registered `tvalid_d1`).

**State machine:** IDLE, SKIP, CAPTURE, TRAIL, DROP.

**IDLE**

- On frame start:
  - if a bank is not full: `wr_bank` = the non-full bank (if both free, the opposite of the last written bank); beat counter = 1; go to SKIP (or to CAPTURE if `SKIP_N`=1).
  - if both banks are full: go to DROP.
- A start beat carrying `tlast` is a truncated frame: pulse `frm_err` and stay in IDLE.

**SKIP**

- Count beats.
- After `SKIP_N` beats total, go to CAPTURE with `grp_idx`=0 and `waddr`=0.

**CAPTURE**

- Per beat, if `grp_idx < KEEP_N`, write `s_tdata[DATA_W-1:0]` to `wr_bank[waddr]` and increment `waddr`.
- `grp_idx` wraps at `GROUP_N`.
- After write number `N_SAMP`, go to TRAIL.
- If that final write carries `tlast`: mark the bank full and go to IDLE.

**TRAIL**

- Discard beats.
- On the `tlast` beat: set `full[wr_bank]`, go to IDLE.

**Truncation**

- A `tlast` beat in SKIP or CAPTURE (before `N_SAMP` writes) means: pulse `frm_err`, bank not marked full, go to IDLE.
- Any partial data in that bank is stale.

**DROP**

- Discard beats until the `tlast` beat, then go to IDLE.
- Increment `drop_cnt` on entry; it saturates at 0xFFFF.

**Bank release and ordering**

- `rd_done` clears `full[rd_sel]`.
- `rd_sel` tracks the oldest full bank via a completion-order bit.
- `rd_done` while `cache_valid`=0 is ignored.

**Host port**

- Reads any bank at any time, unarbitrated.
- It does not affect full flags.

## Timing

**Writes and reads**

- A kept beat at cycle t is readable from cycle t+1.
- Same-cycle write and read of one address returns the old data.

**Frame completion**

- `cache_valid` and `rd_sel` update in the cycle after the completing `tlast` beat.
- `frm_err` asserts in the cycle after the offending beat.

**Simultaneous events**

- `rd_done` in the same cycle as a completion applies both.
- The completing bank is never `rd_sel`'s bank, because a write bank is always non-full.

**Reset values**

- `cache_valid`=0, `rd_sel`=0, `rd_data`=0, `host_data`=0, `frm_err`=0, `busy`=0, `drop_cnt`=0.
- All full flags are 0 and the state is IDLE.
- Memory contents are undefined.

**Reset mid-frame**

- The frame is abandoned immediately.
- The first frame start after `rst_n` rises is accepted normally.

**Stall tolerance:** gaps with `s_tvalid`=0 inside a frame pause all counters; they never restart the frame.

## Configuration

`PH_CACHE_DROP_CNT_EN`:

- **Defined:** the `drop_cnt` port and its 16-bit saturating counter exist.
- **Undefined:** the port and counter are absent. DROP behaviour is unchanged, except that nothing is counted.

## Test plan

All scenarios use default parameters; a frame is 20 skip + 256 capture + 4 trailer beats, `tlast` on the last beat.

1. **Single frame.** Stream one frame with `tdata`=beat index. Required:
   - `cache_valid`=1 and `rd_sel`=0 on the cycle after `tlast`;
   - consumer reads addr 0,1,2,3 → 20,21,24,25;
   - addr 127 → 273.
2. **Ping-pong.** Send two frames, no `rd_done`. Required:
   - banks 0 and 1 both full;
   - host read of bank1 addr0 = second-frame beat 20;
   - `rd_done` → `rd_sel`=1, `cache_valid` stays 1.
3. **Overflow.** Send a third frame while both banks are full. Required:
   - DROP state entered;
   - `drop_cnt`=1;
   - bank contents unchanged;
   - after one `rd_done`, a fourth frame lands in bank 0.
4. **Truncation.** Assert `tlast` at capture beat 100. Required:
   - `frm_err` pulses once;
   - `cache_valid` stays 0;
   - the next full frame completes normally.
5. **Stalls and simultaneous release.** Insert random `s_tvalid`=0 gaps of 1–5 cycles, and pulse `rd_done` on the completion cycle. Required:
   - data identical to scenario 1;
   - the release and the completion are both applied.
6. **Reset mid-capture.** Pulse `rst_n` low mid-capture. Required:
   - all outputs at reset values asynchronously;
   - the next frame is stored in bank 0.
